// File: rtl/riscv_lsu_ctrl_pkg.sv
// Shared encodings for the load/store controller: decoder memory sizes and FSM states.
// The size values match the decoder's mem_size (funct3) field.
package riscv_lsu_ctrl_pkg;

    localparam logic [2:0] LSU_B  = 3'd0;
    localparam logic [2:0] LSU_H  = 3'd1;
    localparam logic [2:0] LSU_W  = 3'd2;
    localparam logic [2:0] LSU_BU = 3'd4;
    localparam logic [2:0] LSU_HU = 3'd5;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StDone   = 2'd2;

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane logic: request misalignment check, byte enables, store-lane
// replication and load-lane extraction with sign/zero extension.
module lsu_data_align
    import riscv_lsu_ctrl_pkg::*;
(
    input  logic [1:0]  req_off,
    input  logic [2:0]  req_size,
    input  logic [1:0]  acc_off,
    input  logic [2:0]  acc_size,
    input  logic [31:0] acc_wd,
    input  logic [31:0] rd_word,
    output logic        misaligned,
    output logic [3:0]  be,
    output logic [31:0] wd_lane,
    output logic [31:0] rd_ext
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sext;

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            LSU_B, LSU_BU: misaligned = 1'b0;
            LSU_H, LSU_HU: misaligned = req_off[0];
            LSU_W:         misaligned = (req_off != 2'b00);
            default:       misaligned = 1'b1;
        endcase
    end

    // acc_size[1:0] distinguishes byte/half/word; bit 2 marks the unsigned loads
    always_comb begin
        be      = 4'b1111;
        wd_lane = acc_wd;
        unique case (acc_size[1:0])
            2'd0: begin
                be      = 4'b0001 << acc_off;
                wd_lane = {4{acc_wd[7:0]}};
            end
            2'd1: begin
                be      = 4'b0011 << acc_off;
                wd_lane = {2{acc_wd[15:0]}};
            end
            default: begin
                be      = 4'b1111;
                wd_lane = acc_wd;
            end
        endcase
    end

    assign byte_lane = rd_word[{acc_off, 3'b000} +: 8];
    assign half_lane = rd_word[{acc_off[1], 4'b0000} +: 16];
    assign sext      = ~acc_size[2];

    always_comb begin
        rd_ext = rd_word;
        unique case (acc_size[1:0])
            2'd0:    rd_ext = {{24{byte_lane[7] & sext}}, byte_lane};
            2'd1:    rd_ext = {{16{half_lane[15] & sext}}, half_lane};
            default: rd_ext = rd_word;
        endcase
    end

endmodule

// File: rtl/riscv_lsu_ctrl.sv
// Load/store controller: latches a core memory request, runs one handshaked bus
// transfer with a timeout, and returns extended load data while stalling the PC.
module riscv_lsu_ctrl
    import riscv_lsu_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_misaligned_o,
    output logic        core_bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_WAIT);

    logic [1:0]      state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [2:0]      size_q, size_d;
    logic            we_q, we_d;
    logic [31:0]     wd_q, wd_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     rd_q, rd_d;
    logic            err_q, err_d;

    logic            req_misaligned;
    logic [3:0]      be;
    logic [31:0]     wd_lane;
    logic [31:0]     rd_ext;
    logic            idle_req;
    logic            accept;
    logic            in_access;

    lsu_data_align u_align (
        .req_off    (core_addr_i[1:0]),
        .req_size   (core_size_i),
        .acc_off    (addr_q[1:0]),
        .acc_size   (size_q),
        .acc_wd     (wd_q),
        .rd_word    (mem_rd_i),
        .misaligned (req_misaligned),
        .be         (be),
        .wd_lane    (wd_lane),
        .rd_ext     (rd_ext)
    );

    // Reset gating keeps the combinational handshake quiet while reset is held
    assign idle_req  = (state_q == StIdle) && core_req_i && !reset_i;
    assign accept    = idle_req && !req_misaligned;
    assign in_access = (state_q == StAccess);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        we_d    = we_q;
        wd_d    = wd_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d  = core_addr_i;
                    size_d  = core_size_i;
                    we_d    = core_we_i;
                    wd_d    = core_wd_i;
                    cnt_d   = '0;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                // A ready in the final wait cycle still wins over the timeout
                if (mem_ready_i) begin
                    if (!we_q) begin
                        rd_d = rd_ext;
                    end
                    err_d   = 1'b0;
                    state_d = StDone;
                end else if (cnt_q == CntMax) begin
                    rd_d    = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            wd_q    <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            we_q    <= we_d;
            wd_q    <= wd_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    assign core_stall_o      = in_access || accept;
    assign core_misaligned_o = idle_req && req_misaligned;
    assign core_rd_o         = rd_q;
    assign core_bus_err_o    = err_q;

    assign mem_req_o  = in_access;
    assign mem_we_o   = in_access && we_q;
    assign mem_be_o   = in_access ? be : 4'b0000;
    assign mem_addr_o = in_access ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_wd_o   = in_access ? wd_lane : 32'h0;

endmodule

// File: tb/tb_riscv_lsu_ctrl.sv
// Randomized bench for riscv_lsu_ctrl: a transaction-level timeline model predicts
// every cycle's outputs; directed cases pin the arithmetic with literal values.
module tb_riscv_lsu_ctrl;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_misaligned_o;
    logic        core_bus_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    riscv_lsu_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk_i             (clk),
        .reset_i           (reset_i),
        .core_req_i        (core_req_i),
        .core_we_i         (core_we_i),
        .core_size_i       (core_size_i),
        .core_addr_i       (core_addr_i),
        .core_wd_i         (core_wd_i),
        .core_rd_o         (core_rd_o),
        .core_stall_o      (core_stall_o),
        .core_misaligned_o (core_misaligned_o),
        .core_bus_err_o    (core_bus_err_o),
        .mem_req_o         (mem_req_o),
        .mem_we_o          (mem_we_o),
        .mem_be_o          (mem_be_o),
        .mem_addr_o        (mem_addr_o),
        .mem_wd_o          (mem_wd_o),
        .mem_rd_i          (mem_rd_i),
        .mem_ready_i       (mem_ready_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Per-cycle expectations, set by the driver just after each rising edge
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_mis, exp_req, exp_we, exp_err, exp_rd_valid;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wd, exp_rd;

    // Samples taken during the most recent transaction, for literal checks
    int          s_stall_cnt, s_req_cnt;
    logic        s_mis, s_err;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wd, s_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic int ref_bytes(input logic [2:0] size);
        if (size == 3'd2) return 4;
        if (size == 3'd1 || size == 3'd5) return 2;
        return 1;
    endfunction

    function automatic logic ref_mis(input logic [2:0] size, input logic [31:0] addr);
        int off;
        off = int'(addr % 4);
        if (size == 3'd3 || size > 3'd5) return 1'b1;
        if (off % ref_bytes(size) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] size, input logic [31:0] addr);
        int v;
        v = ((1 << ref_bytes(size)) - 1) << int'(addr % 4);
        return 4'(v);
    endfunction

    function automatic logic [31:0] ref_wd(input logic [2:0] size, input logic [31:0] wd);
        if (ref_bytes(size) == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (ref_bytes(size) == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] size, input logic [31:0] addr,
                                             input logic [31:0] word);
        logic [31:0] v;
        int off;
        off = int'(addr % 4);
        if (ref_bytes(size) == 1) begin
            v = (word >> (8 * off)) & 32'hFF;
            if (size == 3'd0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (ref_bytes(size) == 2) begin
            v = (word >> (16 * (off / 2))) & 32'hFFFF;
            if (size == 3'd1 && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 32'(core_stall_o), 32'(exp_stall));
            chk("misaligned", 32'(core_misaligned_o), 32'(exp_mis));
            chk("mem_req", 32'(mem_req_o), 32'(exp_req));
            chk("bus_err", 32'(core_bus_err_o), 32'(exp_err));
            if (exp_req) begin
                chk("mem_we", 32'(mem_we_o), 32'(exp_we));
                chk("mem_be", 32'(mem_be_o), 32'(exp_be));
                chk("mem_addr", mem_addr_o, exp_addr);
                if (exp_we) chk("mem_wd", mem_wd_o, exp_wd);
            end
            if (exp_rd_valid) chk("core_rd", core_rd_o, exp_rd);
        end
    end

    task automatic set_idle_exp();
        exp_stall    = 1'b0;
        exp_mis      = 1'b0;
        exp_req      = 1'b0;
        exp_err      = 1'b0;
        exp_rd_valid = 1'b0;
    endtask

    task automatic sample();
        @(negedge clk);
        if (core_stall_o) s_stall_cnt++;
        if (mem_req_o) s_req_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            core_req_i  = 1'b0;
            core_size_i = 3'($urandom);
            core_addr_i = $urandom;
            mem_ready_i = 1'($urandom);
            mem_rd_i    = $urandom;
            set_idle_exp();
            sample();
        end
    endtask

    task automatic run_txn(input logic we, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rdword, input int waits);
        logic mis, to;
        int nacc;
        s_stall_cnt = 0;
        s_req_cnt   = 0;
        mis = ref_mis(size, addr);
        @(posedge clk); #1;
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
        mem_ready_i = 1'($urandom);
        mem_rd_i    = $urandom;
        set_idle_exp();
        exp_stall = !mis;
        exp_mis   = mis;
        sample();
        s_mis = core_misaligned_o;
        if (mis) return;
        to   = (waits > MAX_WAIT);
        nacc = to ? MAX_WAIT + 1 : waits + 1;
        for (int k = 0; k < nacc; k++) begin
            @(posedge clk); #1;
            mem_ready_i = (k == waits);
            mem_rd_i    = (k == waits) ? rdword : $urandom;
            exp_stall = 1'b1;
            exp_mis   = 1'b0;
            exp_req   = 1'b1;
            exp_we    = we;
            exp_be    = ref_be(size, addr);
            exp_addr  = addr & ~32'h3;
            exp_wd    = ref_wd(size, wd);
            sample();
            s_be   = mem_be_o;
            s_wd   = mem_wd_o;
            s_addr = mem_addr_o;
        end
        // The core still presents a (possibly junk) request here; it must be ignored
        @(posedge clk); #1;
        core_req_i  = 1'b1;
        core_size_i = 3'($urandom);
        core_addr_i = $urandom;
        mem_ready_i = 1'($urandom);
        mem_rd_i    = $urandom;
        set_idle_exp();
        exp_err = to;
        if (to) begin
            exp_rd       = 32'h0;
            exp_rd_valid = 1'b1;
        end else if (!we) begin
            exp_rd       = ref_load(size, addr, rdword);
            exp_rd_valid = 1'b1;
        end
        sample();
        s_err = core_bus_err_o;
        s_rd  = core_rd_o;
    endtask

    logic [2:0] load_sizes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        reset_i     = 1'b1;
        core_req_i  = 1'b0;
        core_we_i   = 1'b0;
        core_size_i = 3'd0;
        core_addr_i = 32'h0;
        core_wd_i   = 32'h0;
        mem_rd_i    = 32'h0;
        mem_ready_i = 1'b0;
        set_idle_exp();
        #12;
        chk("rst_stall", 32'(core_stall_o), 32'h0);
        chk("rst_mis", 32'(core_misaligned_o), 32'h0);
        chk("rst_req", 32'(mem_req_o), 32'h0);
        chk("rst_we", 32'(mem_we_o), 32'h0);
        chk("rst_be", 32'(mem_be_o), 32'h0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_wd", mem_wd_o, 32'h0);
        chk("rst_rd", core_rd_o, 32'h0);
        chk("rst_err", 32'(core_bus_err_o), 32'h0);
        @(posedge clk); #1;
        reset_i = 1'b0;
        chk_en  = 1'b1;

        run_txn(1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, 32'h0, 0);
        chk("sw_stall_cycles", 32'(s_stall_cnt), 32'd2);
        chk("sw_req_cycles", 32'(s_req_cnt), 32'd1);
        chk("sw_be", 32'(s_be), 32'hF);
        chk("sw_addr", s_addr, 32'h100);
        chk("sw_wd", s_wd, 32'hDEAD_BEEF);

        run_txn(1'b0, 3'd0, 32'h203, 32'h0, 32'h80FF_1234, 1);
        chk("lb_rd", s_rd, 32'hFFFF_FF80);
        run_txn(1'b0, 3'd4, 32'h203, 32'h0, 32'h80FF_1234, 0);
        chk("lbu_rd", s_rd, 32'h0000_0080);

        run_txn(1'b1, 3'd1, 32'h302, 32'h0000_ABCD, 32'h0, 2);
        chk("sh_be", 32'(s_be), 32'hC);
        chk("sh_wd", s_wd, 32'hABCD_ABCD);

        run_txn(1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 0);
        chk("lw_mis_flag", 32'(s_mis), 32'h1);
        chk("lw_mis_req", 32'(s_req_cnt), 32'h0);
        chk("lw_mis_stall", 32'(s_stall_cnt), 32'h0);

        run_txn(1'b0, 3'd2, 32'h80, 32'h0, 32'h1234_5678, 100);
        chk("to_req_cycles", 32'(s_req_cnt), 32'd16);
        chk("to_err", 32'(s_err), 32'h1);
        chk("to_rd", s_rd, 32'h0);

        run_txn(1'b0, 3'd1, 32'h202, 32'h0, 32'h8001_1234, MAX_WAIT);
        chk("late_ready_err", 32'(s_err), 32'h0);
        chk("late_ready_rd", s_rd, 32'hFFFF_8001);

        // Asynchronous reset in the middle of a 3-wait load
        @(posedge clk); #1;
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = 3'd2;
        core_addr_i = 32'h40;
        mem_ready_i = 1'b0;
        set_idle_exp();
        exp_stall = 1'b1;
        @(posedge clk); #1;
        exp_req   = 1'b1;
        exp_we    = 1'b0;
        exp_be    = 4'hF;
        exp_addr  = 32'h40;
        @(posedge clk); #1;
        chk_en = 1'b0;
        chk("pre_rst_req", 32'(mem_req_o), 32'h1);
        reset_i = 1'b1;
        #1;
        chk("async_rst_req", 32'(mem_req_o), 32'h0);
        chk("async_rst_stall", 32'(core_stall_o), 32'h0);
        #1;
        reset_i    = 1'b0;
        core_req_i = 1'b0;
        set_idle_exp();
        chk_en = 1'b1;
        idle(2);
        run_txn(1'b0, 3'd5, 32'h46, 32'h0, 32'hBEEF_0000, 0);
        chk("post_rst_lhu", s_rd, 32'h0000_BEEF);

        for (int i = 0; i < 300; i++) begin
            logic       we;
            logic [2:0] sz;
            logic [31:0] a;
            int         w;
            int unsigned r;
            we = 1'($urandom);
            r  = $urandom_range(0, 9);
            if (r == 0) sz = 3'($urandom);
            else if (we) sz = 3'($urandom_range(0, 2));
            else sz = load_sizes[$urandom_range(0, 4)];
            a = $urandom;
            if (r > 2) a = a & ~32'(ref_bytes(sz) - 1);
            w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 20))
                                            : int'($urandom_range(0, 2));
            run_txn(we, sz, a, $urandom, $urandom, w);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end

        idle(1);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
